// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// sar_adc_ctrl: successive-approximation ADC sequencer (sample, per-bit settle/decide, result latch).
// Revision 1.0 -- initial release.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start_i,
    input  logic             cmp_i,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int MAX_CYCLES = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [WIDTH-1:0] LSB_ONE     = WIDTH'(1);

    generate
        if (WIDTH < 4 || WIDTH > 12) begin : g_bad_width
            $error("sar_adc_ctrl: WIDTH must lie within 4..12");
        end
        if (SAMPLE_CYCLES < 1) begin : g_bad_sample
            $error("sar_adc_ctrl: SAMPLE_CYCLES must be at least 1");
        end
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("sar_adc_ctrl: SETTLE_CYCLES must be at least 3");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] trial;
    logic             cmp_meta;
    logic             cmp_sync;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] decided;

    // trial holds only the bits already resolved; the bit under test lives in bit_mask
    assign bit_mask = LSB_ONE << bit_idx;
    assign decided  = trial | (cmp_sync ? bit_mask : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_sync <= 1'b0;
        end else begin
            cmp_meta <= cmp_i;
            cmp_sync <= cmp_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            trial    <= '0;
            sample_o <= 1'b0;
            dac_o    <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            data_o   <= '0;
        end else if (!ena) begin
            // abort: everything but the last result returns to idle
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            trial    <= '0;
            sample_o <= 1'b0;
            dac_o    <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state    <= ST_SAMPLE;
                        cnt      <= '0;
                        bit_idx  <= IDX_MSB;
                        trial    <= '0;
                        sample_o <= 1'b1;
                        dac_o    <= '0;
                        busy_o   <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == SAMPLE_LAST) begin
                        state    <= ST_SETTLE;
                        cnt      <= '0;
                        sample_o <= 1'b0;
                        dac_o    <= trial | bit_mask;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_DECIDE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DECIDE: begin
                    trial <= decided;
                    if (bit_idx != '0) begin
                        state   <= ST_SETTLE;
                        bit_idx <= bit_idx - IDX_ONE;
                        dac_o   <= decided | (bit_mask >> 1);
                    end else begin
                        state <= ST_DONE;
                        dac_o <= '0;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    data_o  <= trial;
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    sample_o <= 1'b0;
                    dac_o    <= '0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: conversion resolution in bits; legal range 4..12.
REQ-002 SHALL have parameter SAMPLE_CYCLES, default 2: track/hold sample window length; legal minimum 1.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4: DAC plus comparator settle time per bit; legal minimum 3.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 ena  input  1  block enable; low aborts and holds the block idle.
REQ-008 start_i  input  1  conversion request, level-sampled.
REQ-009 cmp_i  input  1  asynchronous comparator (OTA) output; 1 = analog input >= DAC level.
REQ-010 sample_o  output  1  track/hold control; 1 = track.
REQ-011 dac_o  output  WIDTH  trial code driving the reference DAC.
REQ-012 busy_o  output  1  conversion in progress.
REQ-013 valid_o  output  1  one-cycle pulse; data_o is newly updated.
REQ-014 data_o  output  WIDTH  last completed conversion result.

Function
REQ-015 SHALL pass cmp_i through a 2-flop synchronizer; the DECIDE state SHALL use only the synchronized value.
REQ-016 SHALL implement states IDLE, SAMPLE, SETTLE, DECIDE, DONE.
REQ-017 IDLE: start_i=1 and ena=1 at a clock edge -> SAMPLE; the trial register is cleared and the bit index is set to WIDTH-1.
REQ-018 SAMPLE: sample_o=1 and dac_o=0 for exactly SAMPLE_CYCLES cycles -> SETTLE.
REQ-019 SETTLE: dac_o = trial with the current bit forced to 1, held for exactly SETTLE_CYCLES cycles -> DECIDE.
REQ-020 DECIDE (1 cycle): the current bit is kept if the synchronized cmp is 1 and cleared otherwise; if bit index > 0, decrement it -> SETTLE; else -> DONE.
REQ-021 DONE (1 cycle): data_o <= final trial code, valid_o=1 -> IDLE.
REQ-022 valid_o SHALL rise exactly 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) cycles after the start-accept edge, which is 43 with the defaults.
REQ-023 busy_o SHALL be 1 in SAMPLE, SETTLE, DECIDE and DONE, and 0 in IDLE.
REQ-024 sample_o SHALL be 1 only in SAMPLE; dac_o SHALL be 0 in IDLE, SAMPLE and DONE.
REQ-025 start_i outside IDLE SHALL be ignored; a start held high continuously SHALL begin a new conversion on the cycle after DONE (back-to-back, no lost cycles beyond IDLE).
REQ-026 ena=0 in any state SHALL force IDLE on the next edge, with no valid_o pulse; data_o retains its previous value.
REQ-027 data_o SHALL hold its value between valid_o pulses; an aborted conversion SHALL never update it.
REQ-028 All-ones comparator input SHALL yield a result of all ones; all-zeros SHALL yield 0; arithmetic SHALL be purely bitwise with no overflow path.
REQ-029 Illegal parameter values SHALL raise an elaboration-time error.

Reset
REQ-030 With rst_n=0 at a clock edge: state=IDLE, sample_o=0, dac_o=0, busy_o=0, valid_o=0, data_o=0, synchronizer flops=0, counters=0.
REQ-031 Reset mid-conversion SHALL take precedence over all other inputs and SHALL produce no valid_o pulse.

Verification
REQ-032 Comparator model cmp_i=(dac_o<=8'hA5), one start pulse -> valid_o at cycle 43, data_o=8'hA5, dac_o trial sequence 80,C0,A0,B0,A8,A4,A6,A5.
REQ-033 cmp_i tied to 1 -> data_o=8'hFF; cmp_i tied to 0 -> data_o=8'h00; busy_o high for 43 cycles in each case.
REQ-034 Pulse start_i at cycles 5 and 20 of a running conversion -> both ignored, exactly one valid_o pulse; start_i held high -> consecutive conversions with valid_o pulses 44 cycles apart.
REQ-035 Drop ena at cycle 17 -> IDLE next cycle, busy_o=0, dac_o=0, no valid_o, data_o unchanged from the prior result.
REQ-036 Assert rst_n=0 at cycle 30 of a conversion -> all outputs 0 on the next edge; a fresh start after release -> correct result at cycle 43.
REQ-037 Toggle cmp_i asynchronously outside DECIDE windows -> result depends only on the synchronized value sampled in each DECIDE cycle.
